// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: adder op codes and
// the RV32I funct3 values this stage understands.
package alu_issue_pkg;

    typedef enum logic [2:0] {
        IT_ADD  = 3'd0,
        IT_SUB  = 3'd1,
        IT_SLT  = 3'd2,
        IT_SLTU = 3'd3
    } instr_type_e;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;

endpackage

// File: rtl/alu_issue_ctrl_dec.sv
// funct3/funct7 to adder op decode; flags funct3 values this
// stage does not implement.
module alu_ctrl_dec
    import alu_issue_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic        i_is_imm,
    output instr_type_e o_type,
    output logic        o_ok
);

    always_comb begin
        o_type = IT_ADD;
        o_ok   = 1'b0;
        unique case (1'b1)
            (i_funct3 == F3_ADDSUB): begin
                o_ok   = 1'b1;
                // funct7b5 is part of the immediate for OP-IMM
                o_type = (~i_is_imm & i_funct7b5) ? IT_SUB : IT_ADD;
            end
            (i_funct3 == F3_SLT): begin
                o_ok   = 1'b1;
                o_type = IT_SLT;
            end
            (i_funct3 == F3_SLTU): begin
                o_ok   = 1'b1;
                o_type = IT_SLTU;
            end
            default: begin
                o_ok   = 1'b0;
                o_type = IT_ADD;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-entry ALU issue register with operand select and
// one-deep forwarding from the instruction just handed off.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic            i_is_imm,
    input  logic            i_use_pc,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_alu_result,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_opA,
    output logic [XLEN-1:0] o_opB,
    output logic [2:0]      o_instr_type,
    output logic [4:0]      o_rd,
    output logic            o_err
);

    instr_type_e     dec_type;
    logic            dec_ok;
    logic            accept;
    logic            handoff;
    logic            hit_a;
    logic            hit_b;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;

    logic            valid_q;
    logic            err_q;
    logic            fwd_a;
    logic            fwd_b;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_q;
    instr_type_e     type_q;
    logic [4:0]      rd_q;

    alu_ctrl_dec u_dec (
        .i_funct3   (i_funct3),
        .i_funct7b5 (i_funct7b5),
        .i_is_imm   (i_is_imm),
        .o_type     (dec_type),
        .o_ok       (dec_ok)
    );

    assign o_ready = ~valid_q | i_ready;
    assign accept  = i_valid & o_ready;
    assign handoff = valid_q & i_ready;

    assign sel_a = i_use_pc ? i_pc : i_rs1_data;
    assign sel_b = i_is_imm ? i_imm : i_rs2_data;

    // Only the instruction leaving on this same edge can be a producer
    assign hit_a = handoff & (rd_q != 5'd0) & ~i_use_pc
                 & (i_rs1 == rd_q);
    assign hit_b = handoff & (rd_q != 5'd0) & ~i_is_imm
                 & (i_rs2 == rd_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            fwd_a   <= 1'b0;
            fwd_b   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            type_q  <= IT_ADD;
            rd_q    <= 5'd0;
        end else begin
            err_q <= accept & ~dec_ok;
            if (accept & dec_ok) begin
                valid_q <= 1'b1;
                opa_q   <= sel_a;
                opb_q   <= sel_b;
                type_q  <= dec_type;
                rd_q    <= i_rd;
                fwd_a   <= hit_a;
                fwd_b   <= hit_b;
            end else begin
                if (handoff) begin
                    valid_q <= 1'b0;
                end
                // Capture the forwarded result before it moves on
                if (!accept && fwd_a) begin
                    opa_q <= i_alu_result;
                    fwd_a <= 1'b0;
                end
                if (!accept && fwd_b) begin
                    opb_q <= i_alu_result;
                    fwd_b <= 1'b0;
                end
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_err        = err_q;
    assign o_opA        = fwd_a ? i_alu_result : opa_q;
    assign o_opB        = fwd_b ? i_alu_result : opb_q;
    assign o_instr_type = type_q;
    assign o_rd         = rd_q;

endmodule
